// File: rtl/onehot_pulse_decoder.sv
// ---------------------------------------------------------------------------------------------
// onehot_pulse_decoder
//
// Sequential N-to-2**N binary-to-one-hot decoder. Codes arrive on a valid/ready handshake and
// are buffered in a 2-entry FIFO. Each code is replayed as a one-hot pulse that stays high for
// exactly PULSE_LEN cycles. Successive pulses are separated by exactly GAP_LEN all-zero cycles
// when codes are queued back to back. With GAP_LEN == 0 pulses follow each other with no zero
// cycle in between.
//
// Parameters
//   N          code width; dout is 2**N bits wide
//   PULSE_LEN  cycles a pulse stays asserted (>= 1)
//   GAP_LEN    minimum all-zero cycles between pulses (>= 0)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         block enable; low truncates any pulse, flushes the FIFO, forces dout to zero
//   in_valid   in_code is valid
//   in_ready   a code can be accepted this cycle (combinational from registered state)
//   in_code    binary index to decode
//   dout       one-hot pulse output, or all zero
//   dout_valid high whenever dout is non-zero
//   busy       high while the FIFO holds a code or the sequencer is not idle
// ---------------------------------------------------------------------------------------------
module onehot_pulse_decoder #(
    parameter int unsigned N         = 3,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_code,
    output logic [(2**N)-1:0]   dout,
    output logic                dout_valid,
    output logic                busy
);

    localparam int unsigned OutW   = 2 ** N;
    localparam int unsigned MaxLen = (PULSE_LEN > GAP_LEN) ?
                                     ((PULSE_LEN > 2) ? PULSE_LEN : 2) :
                                     ((GAP_LEN > 2) ? GAP_LEN : 2);
    localparam int unsigned CntW   = $clog2(MaxLen);

    // Reload values are one less than the length: the cycle that loads the counter already
    // counts as the first cycle of the pulse or gap.
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_LEN - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Input FIFO (2 entries)
    // -----------------------------------------------------------------------------------------
    logic [N-1:0] mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   fifo_cnt_q, fifo_cnt_d;

    logic         push;
    logic         pop;
    logic         fifo_nonempty;
    logic [N-1:0] head;

    assign in_ready      = en & rst_n & (fifo_cnt_q != 2'd2);
    assign push          = in_valid & in_ready;
    assign fifo_nonempty = (fifo_cnt_q != 2'd0);
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (!en) begin
            // Disable flushes everything queued; nothing is replayed after re-enable.
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_code;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Pulse sequencer
    // -----------------------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [OutW-1:0]   dout_q, dout_d;
    logic [OutW-1:0]   head_onehot;

    always_comb begin
        head_onehot       = '0;
        head_onehot[head] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    dout_d  = head_onehot;
                    cnt_d   = PulseLoad;
                    state_d = StActive;
                end
            end

            StActive: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (GAP_LEN > 0) begin
                    dout_d  = '0;
                    cnt_d   = GapLoad;
                    state_d = StGap;
                end else if (fifo_nonempty) begin
                    // No gap configured: next pulse follows with no zero cycle.
                    pop    = 1'b1;
                    dout_d = head_onehot;
                    cnt_d  = PulseLoad;
                end else begin
                    dout_d  = '0;
                    state_d = StIdle;
                end
            end

            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (fifo_nonempty) begin
                    // Load straight from the gap so the zero run is exactly GAP_LEN long.
                    pop     = 1'b1;
                    dout_d  = head_onehot;
                    cnt_d   = PulseLoad;
                    state_d = StActive;
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                dout_d  = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        // Disable overrides everything: truncate the pulse, never pop.
        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
            dout_d  = '0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = |dout_q;
    assign busy       = fifo_nonempty | (state_q != StIdle);

    // -----------------------------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------------------------
    a_dout_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dout_q));
    a_fifo_bound:   assert property (@(posedge clk) disable iff (!rst_n) fifo_cnt_q <= 2'd2);

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Bench for onehot_pulse_decoder. Two instances share one stimulus stream: dut0 uses
// PULSE_LEN=4/GAP_LEN=1, dut1 uses PULSE_LEN=4/GAP_LEN=0. Every cycle both are compared
// against a scheduling model: each accepted code starts its pulse at
// max(accept_edge + 1, previous_start + PULSE_LEN + GAP_LEN); disable/reset discards all.
module tb_onehot_pulse_decoder;

    localparam int P = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, in_valid;
    logic [2:0] in_code;
    logic       rdy0, rdy1, dv0, dv1, busy0, busy1;
    logic [7:0] dout0, dout1;

    onehot_pulse_decoder #(.N(3), .PULSE_LEN(4), .GAP_LEN(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy0),
        .in_code(in_code), .dout(dout0), .dout_valid(dv0), .busy(busy0)
    );

    onehot_pulse_decoder #(.N(3), .PULSE_LEN(4), .GAP_LEN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy1),
        .in_code(in_code), .dout(dout1), .dout_valid(dv1), .busy(busy1)
    );

    int     vectors = 0;
    int     miscompares = 0;
    longint t = 0;
    logic   s_rdy0, s_rdy1;

    // Model state per instance
    int         m_cnt   [2] = '{0, 0};
    logic [2:0] m_fifo  [2][2];
    bit         m_act   [2] = '{1'b0, 1'b0};
    logic [2:0] m_code  [2];
    longint     m_start [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, t);
        end
    endtask

    function automatic int gap_of(int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic logic m_ready(int d);
        return rst_n && en && (m_cnt[d] < 2);
    endfunction

    function automatic logic [7:0] m_dout(int d);
        if (m_act[d] && t < m_start[d] + P) return 8'(32'd1 << m_code[d]);
        return 8'h00;
    endfunction

    function automatic logic m_busy(int d);
        return (m_cnt[d] > 0) || (m_act[d] && t < m_start[d] + P + gap_of(d));
    endfunction

    function automatic void model_step(int d);
        bit acc;
        acc = rst_n && en && in_valid && (m_cnt[d] < 2);
        if (!rst_n || !en) begin
            m_cnt[d] = 0;
            m_act[d] = 1'b0;
            return;
        end
        if (m_cnt[d] > 0 && (!m_act[d] || t >= m_start[d] + P + gap_of(d))) begin
            m_code[d]    = m_fifo[d][0];
            m_fifo[d][0] = m_fifo[d][1];
            m_cnt[d]--;
            m_act[d]     = 1'b1;
            m_start[d]   = t;
        end
        if (acc) begin
            m_fifo[d][m_cnt[d]] = in_code;
            m_cnt[d]++;
        end
    endfunction

    // One clock: in_ready sampled at negedge, registered outputs #1 after posedge.
    task automatic cycle();
        @(negedge clk);
        s_rdy0 = rdy0;
        s_rdy1 = rdy1;
        check("in_ready0", rdy0, m_ready(0));
        check("in_ready1", rdy1, m_ready(1));
        @(posedge clk);
        t++;
        model_step(0);
        model_step(1);
        #1;
        check("dout0", dout0, m_dout(0));
        check("dout_valid0", dv0, |m_dout(0));
        check("busy0", busy0, m_busy(0));
        check("dout1", dout1, m_dout(1));
        check("dout_valid1", dv1, |m_dout(1));
        check("busy1", busy1, m_busy(1));
    endtask

    task automatic drain(input int n);
        rst_n    = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    function automatic logic [7:0] t3_exp(int j);
        int p;
        p = j / 5;
        if ((j % 5) < 4) return 8'(32'd1 << p);
        return 8'h00;
    endfunction

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       valid;
        logic [2:0] code;
        logic       exp_ready;
        logic [7:0] exp_dout;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [11];
    int   idx;
    bit   saw_low;

    initial begin
        // Reset for 3 cycles with a code offered, then code 5 accepted and replayed (dut0).
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 8'h00, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'h20, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'h20, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'h20, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'h20, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};

        rst_n    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b1;
        in_code  = 3'd5;

        for (int i = 0; i < 11; i++) begin
            rst_n    = tbl[i].rst_n;
            en       = tbl[i].en;
            in_valid = tbl[i].valid;
            in_code  = tbl[i].code;
            cycle();
            check("tbl_ready", s_rdy0, tbl[i].exp_ready);
            check("tbl_dout", dout0, tbl[i].exp_dout);
            check("tbl_busy", busy0, tbl[i].exp_busy);
        end

        // Stream codes 0..7 with valid held high.
        in_valid = 1'b1;
        in_code  = 3'd0;
        saw_low  = 1'b0;
        cycle();
        check("t3_first_accept", s_rdy0, 1'b1);
        idx = 1;
        for (int j = 0; j < 40; j++) begin
            in_valid = (idx < 8);
            in_code  = 3'(idx);
            cycle();
            check("t3_dout", dout0, t3_exp(j));
            if (in_valid && !s_rdy0) saw_low = 1'b1;
            if (in_valid && s_rdy0) idx++;
        end
        in_valid = 1'b0;
        check("t3_all_accepted", idx, 8);
        check("t3_ready_low_seen", saw_low, 1'b1);
        drain(30);

        // Back-pressure: 3 pushes during the first pulse, third stalls until after a pop.
        in_valid = 1'b1;
        in_code  = 3'd3;
        cycle();
        in_code = 3'd1;
        cycle();
        check("t4_push_b", s_rdy0, 1'b1);
        in_code = 3'd6;
        cycle();
        check("t4_push_c", s_rdy0, 1'b1);
        in_code = 3'd2;
        for (int j = 0; j < 4; j++) begin
            cycle();
            check("t4_stall", s_rdy0, 1'b0);
        end
        cycle();
        check("t4_accept_d", s_rdy0, 1'b1);
        check("t4_pulse_b", dout0, 8'h02);
        in_valid = 1'b0;
        repeat (4) cycle();
        check("t4_pulse_c", dout0, 8'h40);
        repeat (5) cycle();
        check("t4_pulse_d", dout0, 8'h04);
        repeat (4) cycle();
        check("t4_gap_after_d", dout0, 8'h00);
        drain(30);

        // Enable abort on the 2nd pulse cycle with 2 codes queued.
        in_valid = 1'b1;
        in_code  = 3'd4;
        cycle();
        in_code = 3'd0;
        cycle();
        check("t5_first_pulse", dout0, 8'h10);
        in_code = 3'd5;
        cycle();
        in_valid = 1'b0;
        en       = 1'b0;
        cycle();
        check("t5_ready_off", s_rdy0, 1'b0);
        check("t5_dout_off", dout0, 8'h00);
        check("t5_busy_off", busy0, 1'b0);
        check("t5_busy_off1", busy1, 1'b0);
        en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cycle();
            check("t5_no_resume", dout0, 8'h00);
            check("t5_idle_busy", busy0, 1'b0);
        end
        in_valid = 1'b1;
        in_code  = 3'd7;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("t5_new_pulse", dout0, 8'h80);
        drain(10);

        // GAP_LEN=0 instance: 2 then 6 back to back with no zero cycle.
        in_valid = 1'b1;
        in_code  = 3'd2;
        cycle();
        in_code = 3'd6;
        cycle();
        in_valid = 1'b0;
        check("t6_dout_j1", dout1, 8'h04);
        for (int j = 2; j < 10; j++) begin
            cycle();
            check("t6_dout", dout1, (j <= 4) ? 8'h04 : ((j <= 8) ? 8'h40 : 8'h00));
            if (j == 5) check("t6_gap_dut0", dout0, 8'h00);
            if (j == 6) check("t6_second_dut0", dout0, 8'h40);
        end
        drain(10);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(63) != 0);
            en       = ($urandom_range(31) != 0);
            in_valid = $urandom_range(1);
            in_code  = 3'($urandom_range(7));
            cycle();
        end
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
